vector_wb_queue: RTL and testbench
==================================

VECTOR_WB_QUEUE -- requirements
Module: vector_wb_queue

Interface
REQ-001 SHALL expose parameter DEPTH, default 4, number of writeback entries (power of two, >= 2).
REQ-002 SHALL expose parameter NUM_ELEMENTS, default 32, FP16 lanes per vector register.
REQ-003 SHALL expose parameter VREG_IDX_W, default 6, destination-register index width.
REQ-004 SHALL have port CLK  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port nRST  input  1  synchronous, active-low reset.
REQ-006 SHALL have port lane_valid  input  1  lane result present.
REQ-007 SHALL have port lane_vd  input  VREG_IDX_W  destination register.
REQ-008 SHALL have port lane_data  input  16*NUM_ELEMENTS  result vector.
REQ-009 SHALL have port lane_mask  input  NUM_ELEMENTS  per-element write enable.
REQ-010 SHALL have port wb_ready  output  1  queue accepts lane result.
REQ-011 SHALL have port wr_valid  output  1  write request to VRF.
REQ-012 SHALL have port wr_vd, wr_data, wr_mask  output  VREG_IDX_W / 16*NUM_ELEMENTS / NUM_ELEMENTS  write request payload.
REQ-013 SHALL have port wr_ready  input  1  VRF accepts write.
REQ-014 SHALL have port query_vd  input  VREG_IDX_W  scoreboard hazard query.
REQ-015 SHALL have port query_hit  output  1  a held entry targets query_vd.
REQ-016 SHALL have port accomplished  output  1  one-cycle retire pulse.
REQ-017 SHALL have port occupancy  output  $clog2(DEPTH)+1  entries held.

Function
REQ-018 SHALL implement a circular FIFO with head/tail pointers that wrap modulo DEPTH and a separate count.
REQ-019 SHALL assert wb_ready = (count != DEPTH); push occurs when lane_valid && wb_ready.
REQ-020 SHALL drive wr_valid = (count != 0) with payload from the head entry; pop occurs when wr_valid && wr_ready.
REQ-021 SHALL give latency of one cycle: result pushed in cycle N appears on wr_* in cycle N+1 earliest.
REQ-022 SHALL hold wr_* stable while wr_valid && !wr_ready.
REQ-023 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-024 SHALL discard a pushed result whose lane_mask is all zero (no entry allocated) and pulse accomplished the next cycle.
REQ-025 SHALL pulse accomplished (registered) the cycle after each write handshake or discard; at most one pulse per cycle, a discard and a write in the same cycle produce one pulse only for the write and the discard pulse in the following cycle.
REQ-026 SHALL compute query_hit combinationally over valid entries only; an entry leaving this cycle still reports a hit.
REQ-027 SHALL deliver writes in push order; never reorder or merge.

Reset
REQ-028 SHALL, while nRST low at a clock edge, clear pointers, count, pending discard flag and accomplished; all entries invalid.
REQ-029 SHALL output after reset: wb_ready=1, wr_valid=0, wr_vd/wr_data/wr_mask=0, query_hit=0, accomplished=0, occupancy=0.
REQ-030 SHALL, on reset mid-operation, drop all held entries without issuing writes or accomplished pulses.

Configuration
REQ-031 SHALL support macro VWB_BYPASS_EN: when defined and count==0, a push with nonzero mask is forwarded combinationally to wr_* in the same cycle; if wr_ready is high it is consumed without allocation, else it is stored normally.
REQ-032 SHALL, without VWB_BYPASS_EN, never forward combinationally; REQ-021 latency holds strictly.

Structure
REQ-033 SHALL place the wb_entry_t typedef (vd, data, mask) and default constants in vector_pkg.
REQ-034 SHALL keep storage and pointer logic in one sub-module, vector_wb_fifo; hazard compare, discard and accomplished logic in the top.

Verification
REQ-035 SHALL test: reset, push vd=5 mask=all-ones, wr_ready=1 -> wr_valid cycle N+1 with vd=5, accomplished at N+2.
REQ-036 SHALL test: wr_ready=0, push 4 entries -> wb_ready=0, occupancy=4; fifth lane_valid not accepted; release -> vd order preserved.
REQ-037 SHALL test: full FIFO, wr_ready=1 with lane_valid=1 -> no push that cycle; next cycle push and pop together, occupancy stays 3.
REQ-038 SHALL test: push mask=0 -> no wr_valid, accomplished pulse next cycle, occupancy 0.
REQ-039 SHALL test: entries vd=3,9 held, query_vd=9 -> query_hit=1; query_vd=4 -> 0; nRST low -> occupancy 0, no writes.
REQ-040 SHALL test with VWB_BYPASS_EN: empty queue, push vd=7, wr_ready=1 -> wr_valid same cycle, occupancy stays 0.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and default sizing for the vector writeback queue.
// The entry layout {vd, data, mask} is the packing order used throughout.
package vector_pkg;

  localparam int DEFAULT_DEPTH        = 4;
  localparam int DEFAULT_NUM_ELEMENTS = 32;
  localparam int DEFAULT_VREG_IDX_W   = 6;
  localparam int LANE_BITS            = 16;

  typedef struct packed {
    logic [DEFAULT_VREG_IDX_W-1:0]             vd;
    logic [LANE_BITS*DEFAULT_NUM_ELEMENTS-1:0] data;
    logic [DEFAULT_NUM_ELEMENTS-1:0]           mask;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/vector_wb_fifo.sv
// Circular entry store for the writeback queue: head/tail pointers, a separate
// count and per-slot valid bits. The top TAG_W bits of each slot are exported for hazard checks.
module vector_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int TAG_W = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [W-1:0]                push_data,
  input  logic                        pop,
  output logic [W-1:0]                head_data,
  output logic [CNT_W-1:0]            count,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH-1:0][TAG_W-1:0] entry_tags
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        mem[tail]         <= push_data;
        entry_valid[tail] <= 1'b1;
        tail              <= tail + 1'b1;
      end
      if (pop) begin
        entry_valid[head] <= 1'b0;
        head              <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];

  always_comb begin
    entry_tags = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_tags[i] = mem[i][W-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/vector_wb_queue.sv
// Writeback queue between the vector lanes and the VRF write port, with hazard
// query and retire pulses. Define VWB_BYPASS_EN to forward into an empty queue combinationally.
module vector_wb_queue
  import vector_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int NUM_ELEMENTS = DEFAULT_NUM_ELEMENTS,
  parameter int VREG_IDX_W   = DEFAULT_VREG_IDX_W,
  localparam int DATA_W      = LANE_BITS * NUM_ELEMENTS,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    lane_valid,
  input  logic [VREG_IDX_W-1:0]   lane_vd,
  input  logic [DATA_W-1:0]       lane_data,
  input  logic [NUM_ELEMENTS-1:0] lane_mask,
  output logic                    wb_ready,
  output logic                    wr_valid,
  output logic [VREG_IDX_W-1:0]   wr_vd,
  output logic [DATA_W-1:0]       wr_data,
  output logic [NUM_ELEMENTS-1:0] wr_mask,
  input  logic                    wr_ready,
  input  logic [VREG_IDX_W-1:0]   query_vd,
  output logic                    query_hit,
  output logic                    accomplished,
  output logic [CNT_W-1:0]        occupancy
);

  localparam int ENTRY_W = VREG_IDX_W + DATA_W + NUM_ELEMENTS;
  localparam int PEND_W  = 4;

  logic [CNT_W-1:0]                 count;
  logic [ENTRY_W-1:0]               head_entry;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][VREG_IDX_W-1:0] entry_vd;
  logic                             accept;
  logic                             mask_zero;
  logic                             discard;
  logic                             bypass;
  logic                             handshake;
  logic                             fifo_push;
  logic                             fifo_pop;
  logic [PEND_W-1:0]                pend_cnt;
  logic [PEND_W-1:0]                pend_next;
  logic                             acc_next;

  vector_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W),
    .TAG_W (VREG_IDX_W)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (nRST),
    .push        (fifo_push),
    .push_data   ({lane_vd, lane_data, lane_mask}),
    .pop         (fifo_pop),
    .head_data   (head_entry),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_tags  (entry_vd)
  );

  assign occupancy = count;
  assign wb_ready  = (count != CNT_W'(DEPTH));
  assign accept    = lane_valid && wb_ready;
  assign mask_zero = (lane_mask == '0);
  assign discard   = accept && mask_zero;

`ifdef VWB_BYPASS_EN
  assign bypass = accept && !mask_zero && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign wr_valid  = (count != '0) || bypass;
  assign handshake = wr_valid && wr_ready;
  assign fifo_pop  = (count != '0) && wr_ready;
  // A forwarded result that the VRF takes immediately never occupies a slot.
  assign fifo_push = accept && !mask_zero && !(bypass && wr_ready);

  always_comb begin
    wr_vd   = '0;
    wr_data = '0;
    wr_mask = '0;
    if (count != '0) begin
      {wr_vd, wr_data, wr_mask} = head_entry;
    end else if (bypass) begin
      wr_vd   = lane_vd;
      wr_data = lane_data;
      wr_mask = lane_mask;
    end
  end

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_vd[i] == query_vd)) begin
        query_hit = 1'b1;
      end
    end
  end

  // Writes own the pulse slot; discards that collide with one wait in pend_cnt.
  always_comb begin
    acc_next  = 1'b0;
    pend_next = pend_cnt;
    if (handshake) begin
      acc_next = 1'b1;
      if (discard && (pend_cnt != '1)) begin
        pend_next = pend_cnt + 1'b1;
      end
    end else if (pend_cnt != '0) begin
      acc_next = 1'b1;
      if (!discard) begin
        pend_next = pend_cnt - 1'b1;
      end
    end else begin
      acc_next = discard;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      accomplished <= 1'b0;
      pend_cnt     <= '0;
    end else begin
      accomplished <= acc_next;
      pend_cnt     <= pend_next;
    end
  end

endmodule

// File: tb/tb_vector_wb_queue.sv
// Directed self-checking bench for vector_wb_queue; the same-cycle forwarding
// case runs only when VWB_BYPASS_EN is defined.
module tb_vector_wb_queue;
  import vector_pkg::*;

  localparam int NE     = DEFAULT_NUM_ELEMENTS;
  localparam int VW     = DEFAULT_VREG_IDX_W;
  localparam int DW     = LANE_BITS * NE;
  localparam int CW     = $clog2(DEFAULT_DEPTH) + 1;

  logic          CLK;
  logic          nRST;
  logic          lane_valid;
  logic [VW-1:0] lane_vd;
  logic [DW-1:0] lane_data;
  logic [NE-1:0] lane_mask;
  logic          wb_ready;
  logic          wr_valid;
  logic [VW-1:0] wr_vd;
  logic [DW-1:0] wr_data;
  logic [NE-1:0] wr_mask;
  logic          wr_ready;
  logic [VW-1:0] query_vd;
  logic          query_hit;
  logic          accomplished;
  logic [CW-1:0] occupancy;

  int total;
  int bad;

  vector_wb_queue dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .lane_valid   (lane_valid),
    .lane_vd      (lane_vd),
    .lane_data    (lane_data),
    .lane_mask    (lane_mask),
    .wb_ready     (wb_ready),
    .wr_valid     (wr_valid),
    .wr_vd        (wr_vd),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .wr_ready     (wr_ready),
    .query_vd     (query_vd),
    .query_hit    (query_hit),
    .accomplished (accomplished),
    .occupancy    (occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] mkData(input logic [VW-1:0] vd);
    logic [DW-1:0] d;
    for (int e = 0; e < NE; e++) begin
      d[e*LANE_BITS +: LANE_BITS] = {e[3:0], 6'h2A, vd};
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [VW-1:0] vd,
                               input logic [NE-1:0] mask, input logic ready);
    wb_entry_t ent;
    ent.vd     = vd;
    ent.data   = mkData(vd);
    ent.mask   = mask;
    lane_valid = valid;
    lane_vd    = ent.vd;
    lane_data  = ent.data;
    lane_mask  = ent.mask;
    wr_ready   = ready;
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [VW-1:0] vd);
    logic [DW-1:0] d;
    d = mkData(vd);
    checkOutput({tag, "_valid"}, 64'(wr_valid), 64'd1);
    checkOutput({tag, "_vd"}, 64'(wr_vd), 64'(vd));
    checkOutput({tag, "_data"}, wr_data[63:0], d[63:0]);
  endtask

  localparam logic [NE-1:0] ONES = '1;

  initial begin
    total    = 0;
    bad      = 0;
    nRST     = 1'b0;
    query_vd = '0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    stepCycle();
    stepCycle();

    checkOutput("rst_wb_ready", 64'(wb_ready), 64'd1);
    checkOutput("rst_wr_valid", 64'(wr_valid), 64'd0);
    checkOutput("rst_wr_vd", 64'(wr_vd), 64'd0);
    checkOutput("rst_wr_mask", 64'(wr_mask), 64'd0);
    checkOutput("rst_wr_data", wr_data[63:0], 64'd0);
    checkOutput("rst_query_hit", 64'(query_hit), 64'd0);
    checkOutput("rst_accomplished", 64'(accomplished), 64'd0);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    nRST = 1'b1;
    stepCycle();

`ifndef VWB_BYPASS_EN
    // single push, one-cycle latency, retire pulse two cycles later
    applyStimulus(1'b1, 6'd5, ONES, 1'b1);
    checkOutput("lat_no_forward", 64'(wr_valid), 64'd0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkHead("lat_n1", 6'd5);
    checkOutput("lat_n1_mask", 64'(wr_mask), 64'(ONES));
    checkOutput("lat_n1_acc", 64'(accomplished), 64'd0);
    stepCycle();
    checkOutput("lat_n2_acc", 64'(accomplished), 64'd1);
    checkOutput("lat_n2_valid", 64'(wr_valid), 64'd0);
    checkOutput("lat_n2_occ", 64'(occupancy), 64'd0);
    stepCycle();
    checkOutput("lat_n3_acc", 64'(accomplished), 64'd0);
`else
    // forwarded write into an empty queue
    applyStimulus(1'b1, 6'd7, ONES, 1'b1);
    checkHead("byp", 6'd7);
    checkOutput("byp_occ", 64'(occupancy), 64'd0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("byp_occ_after", 64'(occupancy), 64'd0);
    checkOutput("byp_valid_after", 64'(wr_valid), 64'd0);
    checkOutput("byp_acc", 64'(accomplished), 64'd1);
    applyStimulus(1'b1, 6'd8, ONES, 1'b0);
    checkHead("byp_stall", 6'd8);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkOutput("byp_stall_occ", 64'(occupancy), 64'd1);
    checkHead("byp_stall_held", 6'd8);
    wr_ready = 1'b1;
    stepCycle();
    stepCycle();
`endif

    // fill with VRF stalled, reject a fifth, then drain in order
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 6'(k), ONES, 1'b0);
      stepCycle();
    end
    checkOutput("full_wb_ready", 64'(wb_ready), 64'd0);
    checkOutput("full_occ", 64'(occupancy), 64'd4);
    applyStimulus(1'b1, 6'd10, ONES, 1'b0);
    stepCycle();
    checkOutput("full_reject_occ", 64'(occupancy), 64'd4);
    checkHead("full_stable", 6'd1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      checkHead($sformatf("drain%0d", k), 6'(k));
      if (k > 1) checkOutput($sformatf("drain%0d_acc", k), 64'(accomplished), 64'd1);
      stepCycle();
    end
    checkOutput("drain_empty_occ", 64'(occupancy), 64'd0);
    checkOutput("drain_empty_valid", 64'(wr_valid), 64'd0);
    stepCycle();

    // full queue with push and pop offered together
    for (int k = 11; k <= 14; k++) begin
      applyStimulus(1'b1, 6'(k), ONES, 1'b0);
      stepCycle();
    end
    applyStimulus(1'b1, 6'd15, ONES, 1'b1);
    checkOutput("pp_full_ready", 64'(wb_ready), 64'd0);
    stepCycle();
    checkOutput("pp_occ_a", 64'(occupancy), 64'd3);
    checkOutput("pp_ready_a", 64'(wb_ready), 64'd1);
    checkHead("pp_head_a", 6'd12);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("pp_occ_b", 64'(occupancy), 64'd3);
    for (int k = 13; k <= 15; k++) begin
      checkHead($sformatf("pp_drain%0d", k), 6'(k));
      stepCycle();
    end
    checkOutput("pp_empty_occ", 64'(occupancy), 64'd0);
    stepCycle();

    // all-zero mask is discarded but still retires
    applyStimulus(1'b1, 6'd20, '0, 1'b1);
    checkOutput("disc_no_write", 64'(wr_valid), 64'd0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("disc_acc", 64'(accomplished), 64'd1);
    checkOutput("disc_valid", 64'(wr_valid), 64'd0);
    checkOutput("disc_occ", 64'(occupancy), 64'd0);
    stepCycle();
    checkOutput("disc_acc_end", 64'(accomplished), 64'd0);

    // discard colliding with a write: two pulses on consecutive cycles
    applyStimulus(1'b1, 6'd21, ONES, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 6'd22, '0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("coll_acc_wr", 64'(accomplished), 64'd1);
    checkOutput("coll_occ", 64'(occupancy), 64'd0);
    stepCycle();
    checkOutput("coll_acc_disc", 64'(accomplished), 64'd1);
    stepCycle();
    checkOutput("coll_acc_end", 64'(accomplished), 64'd0);

    // hazard query, then reset drops held entries
    applyStimulus(1'b1, 6'd3, ONES, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 6'd9, ONES, 1'b0);
    stepCycle();
    applyStimulus(1'b0, '0, '0, 1'b0);
    query_vd = 6'd9;
    #1;
    checkOutput("haz_hit9", 64'(query_hit), 64'd1);
    query_vd = 6'd4;
    #1;
    checkOutput("haz_miss4", 64'(query_hit), 64'd0);
    query_vd = 6'd3;
    wr_ready = 1'b1;
    #1;
    checkOutput("haz_hit3_leaving", 64'(query_hit), 64'd1);
    wr_ready = 1'b0;
    nRST     = 1'b0;
    stepCycle();
    wr_ready = 1'b1;
    checkOutput("mid_rst_occ", 64'(occupancy), 64'd0);
    checkOutput("mid_rst_valid", 64'(wr_valid), 64'd0);
    checkOutput("mid_rst_acc", 64'(accomplished), 64'd0);
    nRST = 1'b1;
    stepCycle();
    checkOutput("post_rst_valid", 64'(wr_valid), 64'd0);
    checkOutput("post_rst_acc", 64'(accomplished), 64'd0);
    query_vd = 6'd9;
    #1;
    checkOutput("post_rst_hit", 64'(query_hit), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
